// File: rtl/insn_mem.sv
`default_nettype none
// ============================================================================
// Module   : insn_mem
// Purpose  : Synchronous simple dual-port RAM (one write port, one read port)
//            with per-byte write enables and a registered read output.
//            Serves as the instruction store (fetch reads with PC[9:2]) and
//            as the bimodal 2-bit counter table (read with GHR, written by
//            execute using byte enables).
// Ports    : clock      - single clock, all state updates on rising edge
//            reset      - asynchronous active-low; clears q only, never the
//                         array; writes are ignored while it is low
//            byteena_a  - per-byte write enable, bit i covers data[8i+7:8i]
//            data       - write data
//            wraddress  - write address
//            wren       - write strobe
//            rdaddress  - read address, read every cycle (no read enable)
//            q          - read data, driven straight from flops
// Revision : 1.0 - initial release
// ============================================================================
module insn_mem #(
  parameter int WIDTH  = 32,           // multiple of 8
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,          // 2**ADDR_W
  parameter int NBYTES = 4             // WIDTH / 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NBYTES-1:0] byteena_a,
  input  logic [WIDTH-1:0]  data,
  input  logic [ADDR_W-1:0] wraddress,
  input  logic              wren,
  input  logic [ADDR_W-1:0] rdaddress,
  output logic [WIDTH-1:0]  q
);

  localparam int c_LANE_W = 8;

  // Storage is split into one 8-bit-wide array per byte lane. Each lane then
  // has an unconditional-width write, so byte enables map to per-lane write
  // enables and no read-modify-write of the full word is needed.
  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      // Contents power up to zero; reset never touches the array.
      logic [c_LANE_W-1:0] r_mem [DEPTH] = '{default: '0};
      logic [c_LANE_W-1:0] r_q;

      // The array write lives in the reset-qualified branch so that a write
      // presented while reset is low is dropped, without using reset as a
      // synchronous data input anywhere else.
      //
      // Read and write of the same address on the same edge: the read
      // samples the array before the non-blocking write lands, so q returns
      // the old byte and the new byte shows from the next edge onward.
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_q <= '0;
        end else begin
          r_q <= r_mem[rdaddress];
          if (wren && byteena_a[gi]) begin
            r_mem[wraddress] <= data[c_LANE_W*gi +: c_LANE_W];
          end
        end
      end

      assign q[c_LANE_W*gi +: c_LANE_W] = r_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_insn_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_insn_mem
// Purpose  : Self-checking bench for insn_mem. Expected read data comes from
//            a behavioural word-array model and is queued when the read
//            address is driven, then popped and compared after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_insn_mem;

  logic        clock;
  logic        reset;
  logic [3:0]  byteena_a;
  logic [31:0] data;
  logic [7:0]  wraddress;
  logic        wren;
  logic [7:0]  rdaddress;
  logic [31:0] q;

  logic [31:0] model [256];
  logic [31:0] sb [$];
  int          n_vec;
  int          n_err;

  insn_mem #(
    .WIDTH  (32),
    .ADDR_W (8),
    .DEPTH  (256),
    .NBYTES (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .byteena_a (byteena_a),
    .data      (data),
    .wraddress (wraddress),
    .wren      (wren),
    .rdaddress (rdaddress),
    .q         (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drive one cycle of stimulus (called 1 time unit after a rising edge),
  // queue the expected read word from the model (pre-write contents), update
  // the model for the write, then advance to 1 time unit after the next edge.
  task automatic step(input logic wr, input logic [3:0] be, input logic [7:0] wa,
                      input logic [31:0] d, input logic [7:0] ra, input bit chk);
    wren      = wr;
    byteena_a = be;
    wraddress = wa;
    data      = d;
    rdaddress = ra;
    if (chk) sb.push_back(model[ra]);
    if (wr && reset) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) model[wa][8*b +: 8] = d[8*b +: 8];
      end
    end
    @(posedge clock);
    #1;
    wren = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] exp;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      n_vec++;
      if (q !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d: q=%h expected %h", c, q, 32'h0);
      end
    end
    rdaddress = 8'h00;
    reset = 1'b1;
    #1;
    n_vec++;
    if (q !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release_noedge: q=%h expected %h", q, 32'h0);
    end
    #1;
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h00, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h0) begin
      n_err++;
      $display("FAIL powerup_addr0: q=%h expected %h", q, exp);
    end
  endtask

  task automatic test_full_write();
    logic [31:0] exp;
    step(1'b1, 4'hF, 8'h05, 32'hDEADBEEF, 8'h00, 1'b0);
    // read 05 while writing a different address: independent ports
    step(1'b1, 4'hF, 8'h07, 32'h01234567, 8'h05, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL full_write_05: q=%h expected %h", q, exp);
    end
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h06, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h0) begin
      n_err++;
      $display("FAIL untouched_06: q=%h expected %h", q, exp);
    end
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h07, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp) begin
      n_err++;
      $display("FAIL diff_addr_write_07: q=%h expected %h", q, exp);
    end
  endtask

  task automatic test_byte_enables();
    logic [31:0] exp;
    step(1'b1, 4'b0101, 8'h05, 32'h11223344, 8'h00, 1'b0);
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h05, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'hDE22BE44) begin
      n_err++;
      $display("FAIL byteena_0101: q=%h expected %h", q, exp);
    end
    step(1'b1, 4'b0000, 8'h05, 32'hFFFFFFFF, 8'h00, 1'b0);
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h05, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'hDE22BE44) begin
      n_err++;
      $display("FAIL byteena_none: q=%h expected %h", q, exp);
    end
  endtask

  task automatic test_rdw_same_addr();
    logic [31:0] exp;
    step(1'b1, 4'hF, 8'hFF, 32'hAAAAAAAA, 8'h00, 1'b0);
    step(1'b1, 4'hF, 8'hFF, 32'h55555555, 8'hFF, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'hAAAAAAAA) begin
      n_err++;
      $display("FAIL rdw_old_data: q=%h expected %h", q, exp);
    end
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'hFF, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h55555555) begin
      n_err++;
      $display("FAIL rdw_new_data: q=%h expected %h", q, exp);
    end
    // partial-byte read-during-write: only lane 1 written, old word returned
    step(1'b1, 4'b0010, 8'hFF, 32'h0000C300, 8'hFF, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h55555555) begin
      n_err++;
      $display("FAIL rdw_partial_old: q=%h expected %h", q, exp);
    end
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'hFF, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h5555C355) begin
      n_err++;
      $display("FAIL rdw_partial_new: q=%h expected %h", q, exp);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] exp;
    logic [7:0]  a;
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      step(1'b1, 4'hF, a, {4{a}}, 8'h00, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      a = 8'(i);
      step(1'b0, 4'h0, 8'h00, 32'h0, a, 1'b1);
      exp = sb.pop_front();
      n_vec++;
      if (q !== exp || q !== {4{a}}) begin
        n_err++;
        $display("FAIL sweep_read addr=%h: q=%h expected %h", a, q, exp);
      end
    end
    // bimodal-style update of byte 2 only
    step(1'b1, 4'b0100, 8'h10, 32'hFF03FFFF, 8'h00, 1'b0);
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h10, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h10031010) begin
      n_err++;
      $display("FAIL bimodal_byte2: q=%h expected %h", q, exp);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 4'h0, 8'h00, 32'h0, 8'h20 + 8'(i), 1'b1);
      exp = sb.pop_front();
      n_vec++;
      if (q !== exp) begin
        n_err++;
        $display("FAIL stream_read%0d: q=%h expected %h", i, q, exp);
      end
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if (q !== 32'h0) begin
      n_err++;
      $display("FAIL async_reset_assert: q=%h expected %h", q, 32'h0);
    end
    @(posedge clock);
    #1;
    // write attempted during reset must be dropped
    step(1'b1, 4'hF, 8'h05, 32'hCAFEF00D, 8'h05, 1'b0);
    n_vec++;
    if (q !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hold_edge: q=%h expected %h", q, 32'h0);
    end
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if (q !== 32'h0) begin
      n_err++;
      $display("FAIL midreset_release_noedge: q=%h expected %h", q, 32'h0);
    end
    @(posedge clock);
    #1;
    step(1'b0, 4'h0, 8'h00, 32'h0, 8'h05, 1'b1);
    exp = sb.pop_front();
    n_vec++;
    if (q !== exp || q !== 32'h05050505) begin
      n_err++;
      $display("FAIL array_survives_reset: q=%h expected %h", q, exp);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    reset     = 1'b0;
    wren      = 1'b0;
    byteena_a = 4'h0;
    data      = 32'h0;
    wraddress = 8'h00;
    rdaddress = 8'h00;
    for (int i = 0; i < 256; i++) model[i] = 32'h0;
    #1;
    n_vec++;
    if (q !== 32'h0) begin
      n_err++;
      $display("FAIL reset_initial: q=%h expected %h", q, 32'h0);
    end

    test_reset();
    test_full_write();
    test_byte_enables();
    test_rdw_same_addr();
    test_sweep();
    test_reset_midstream();

    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop so a stalled run still ends.
  initial begin
    #100000;
    $display("FAIL timeout: sim time limit reached expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/insn_mem.md
# insn_mem

Synchronous simple dual-port RAM, 256 words × 32 bits, with per-byte write enables. The branch-predictor front end uses two instances of this block:
- **Instruction store:** written by the loader and read by fetch with `PC[9:2]`; `byteena_a` is tied to 4'b1111.
- **Bimodal counter table:** 16 two-bit counters per word, read with the GHR and written by execute with byte enables.

The block has one write port and one read port, and reads are registered with one-cycle latency.

## Interface

Parameters:
- `WIDTH`, 32: data word width; must be a multiple of 8.
- `ADDR_W`, 8: address width.
- `DEPTH`, 256: number of words, equal to 2^`ADDR_W`.
- `NBYTES`, 4: number of byte lanes, equal to `WIDTH`/8.

Ports:
- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low; clears the read output register only.
- `byteena_a`  in  `NBYTES`: per-byte write enable; bit i covers `data[8i+7:8i]`.
- `data`  in  `WIDTH`: write data.
- `wraddress`  in  `ADDR_W`: write address.
- `wren`  in  1: write strobe.
- `rdaddress`  in  `ADDR_W`: read address; always reading, no read enable.
- `q`  out  `WIDTH`: registered read data.

## Operation

- Storage is `DEPTH` × `WIDTH` bits. Contents power up to all zeros.
- `reset` never alters the array. Bimodal table clearing is done externally by sweeping writes.
- **Write:** on a rising edge with `wren`=1, each byte lane i with `byteena_a[i]`=1 takes `data[8i+7:8i]` into `mem[wraddress]`.
  - Lanes with `byteena_a[i]`=0 keep their old value.
  - With `wren`=1 and `byteena_a`=0, nothing changes.
- **Read:** on every rising edge, `q` loads `mem[rdaddress]`. There is no read enable and no stall input; the caller freezes the address to hold a value.
- **Read-during-write, same address, same edge:** `q` returns the OLD word, i.e. the contents before the write. The new data is visible from the next read edge onward. This applies per byte, including partial-byte writes.
- **Different addresses:** read and write are fully independent in the same cycle.
- **Reset:** `reset`=0 forces `q` to 0 immediately, asynchronously, and holds it at 0. Writes are ignored while `reset`=0.
- **Address range:** all addresses 0..`DEPTH`-1 are valid. There is no wrap or out-of-range case, since `DEPTH` = 2^`ADDR_W`.
- **Unknowns:** `X` on `byteena_a`, `wren` or `wraddress` while writing is a caller error. The block does not need to protect against it.

## Timing

- **Read latency:** 1 cycle. The address applied before edge N appears on `q` after edge N and stays stable until edge N+1.
- **Write-to-read latency:** a write at edge N is readable at `q` after edge N+1, provided `rdaddress` is presented before edge N+1.
- **Reset assertion:** `q` goes to 0 without waiting for a clock edge.
- **Reset release:** `q` stays 0 until the first rising edge with `reset`=1. It then loads `mem[rdaddress]`.
- **Outputs:** `q` is driven directly from a flop, with no combinational path from the inputs to `q`. Fetch logic relies on this to compute the next PC in the same cycle.
- **Inputs:** all inputs are sampled only on the rising edge of `clock`, except `reset`.

## Test plan

1. **Reset and power-up:**
   - Hold `reset`=0 for 3 cycles: `q`=0.
   - Release with `rdaddress`=8'h00: after the next edge, `q`=32'h0 (power-up contents).
2. **Full write then read:**
   - Write 32'hDEADBEEF to addr 8'h05 with `byteena_a`=4'hF.
   - Next cycle `rdaddress`=8'h05: after that edge, `q`=32'hDEADBEEF.
   - Addr 8'h06 still reads 0.
3. **Byte enables:**
   - After scenario 2, write `data`=32'h11223344 to 8'h05 with `byteena_a`=4'b0101.
   - Read 8'h05: `q`=32'hDE22BE44.
   - Then write with `wren`=1, `byteena_a`=0: the word is unchanged.
4. **Read-during-write, same address:**
   - Addr 8'hFF holds 32'hAAAAAAAA.
   - At one edge, write 32'h55555555 to 8'hFF while `rdaddress`=8'hFF: `q`=32'hAAAAAAAA.
   - At the next edge: `q`=32'h55555555.
5. **Sweep and bimodal usage:**
   - Write addr i with {4{i}} for i=0..255, then read back all 256 in consecutive cycles.
   - Each read returns {4{i}}, one cycle after its address.
   - Repeat the pattern 2-bit-counter style: update only byte 2 of addr 8'h10 (`byteena_a`=4'b0100) and check the other three bytes are untouched.
6. **Reset mid-stream:**
   - While streaming reads, drop `reset` between edges: `q`=0 immediately.
   - Array contents survive: after release, re-reading addr 8'h05 returns its previous value.
   - A write attempted during reset has no effect.
